// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register: the mode encoding
// used on the 2-bit mode input.
package univ_shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

endpackage

// File: rtl/shift_cnt.sv
// Shift counter for the universal shift register. Counts shifts since the
// last load, reset or wrap, and pulses word_done on the shift that
// completes a full word of WIDTH shifts. State changes on the falling edge.
module shift_cnt #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic             word_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    // Count shifts, wrap at WIDTH-1 with a one-cycle pulse; reset/load clear without a pulse
    always_ff @(negedge clk) begin
        if (rst || clear) begin
            cnt       <= '0;
            word_done <= 1'b0;
        end else if (shift_en) begin
            if (cnt == CNT_MAX) begin
                cnt       <= '0;
                word_done <= 1'b1;
            end else begin
                cnt       <= cnt + CNT_W'(1);
                word_done <= 1'b0;
            end
        end else begin
            word_done <= 1'b0;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, shift right, shift left and
// parallel load, with a shift counter and word-complete pulse.
// All state updates on the falling edge of clk; rst is synchronous.
// Optional build macro UNIV_SHIFT_ROTATE_EN turns the shifts into rotates
// (the serial inputs are then ignored); the port list is the same either way.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] cnt,
    output logic             word_done
);

    mode_t mode_dec;
    logic  shift_en;
    logic  clear;
    logic  fill_msb;
    logic  fill_lsb;

`ifdef UNIV_SHIFT_ROTATE_EN
    assign fill_msb = q[0];
    assign fill_lsb = q[WIDTH-1];
`else
    assign fill_msb = sin_r;
    assign fill_lsb = sin_l;
`endif

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    // Decode the mode into counter controls; anything unrecognised behaves as hold
    always_comb begin
        mode_dec = mode_t'(mode);
        shift_en = 1'b0;
        clear    = 1'b0;
        case (mode_dec)
            MODE_SHR,
            MODE_SHL:  shift_en = 1'b1;
            MODE_LOAD: clear    = 1'b1;
            default:   ;
        endcase
    end

    // Data path: reset first, then hold / shift / load by mode
    always_ff @(negedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (mode_dec)
                MODE_SHR:  q <= {fill_msb, q[WIDTH-1:1]};
                MODE_SHL:  q <= {q[WIDTH-2:0], fill_lsb};
                MODE_LOAD: q <= pin;
                default:   q <= q;
            endcase
        end
    end

    shift_cnt #(
        .WIDTH(WIDTH)
    ) u_shift_cnt (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clear    (clear),
        .cnt      (cnt),
        .word_done(word_done)
    );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg: a WIDTH=4 instance runs
// the main sequence and a WIDTH=8 instance covers the wide-word wrap.
module tb_univ_shift_reg;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [3:0] pin;
    logic [3:0] q;
    logic       sout_r;
    logic       sout_l;
    logic [1:0] cnt;
    logic       word_done;

    logic       rst8;
    logic [1:0] mode8;
    logic       sin_r8;
    logic       sin_l8;
    logic [7:0] pin8;
    logic [7:0] q8;
    logic       sout_r8;
    logic       sout_l8;
    logic [2:0] cnt8;
    logic       word_done8;

    int compared;
    int mismatched;

    univ_shift_reg #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .sin_r    (sin_r),
        .sin_l    (sin_l),
        .pin      (pin),
        .q        (q),
        .sout_r   (sout_r),
        .sout_l   (sout_l),
        .cnt      (cnt),
        .word_done(word_done)
    );

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst8),
        .mode     (mode8),
        .sin_r    (sin_r8),
        .sin_l    (sin_l8),
        .pin      (pin8),
        .q        (q8),
        .sout_r   (sout_r8),
        .sout_l   (sout_l8),
        .cnt      (cnt8),
        .word_done(word_done8)
    );

    // Free-running clock; the DUT acts on falling edges
    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] eq,
                               input logic [1:0] ecnt, input logic ewd);
        check_output({tag, ".q"},         32'(q),         32'(eq));
        check_output({tag, ".cnt"},       32'(cnt),       32'(ecnt));
        check_output({tag, ".word_done"}, 32'(word_done), 32'(ewd));
    endtask

    // Drive the narrow instance's inputs; an unknown mode is a bench error
    task automatic apply_stimulus(input logic r, input logic [1:0] m,
                                  input logic sr, input logic sl, input logic [3:0] p);
        rst   = r;
        mode  = m;
        sin_r = sr;
        sin_l = sl;
        pin   = p;
        compared++;
        assert (!$isunknown(m))
        else begin
            mismatched++;
            $error("[TB] FAIL mode_known observed=%b expected=known", m);
        end
    endtask

    // Advance one falling edge and settle before sampling
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [3:0] rot_last;
    logic [7:0] wide_last;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst8 = 1'b1; mode8 = 2'b00; sin_r8 = 1'b0; sin_l8 = 1'b0; pin8 = 8'h00;

        // Reset state
        apply_stimulus(1'b1, 2'b00, 1'b0, 1'b0, 4'b0000);
        tick();
        check_state("reset", 4'b0000, 2'd0, 1'b0);

        // 1: load 1011 then reset
        apply_stimulus(1'b0, 2'b11, 1'b0, 1'b0, 4'b1011);
        tick();
        check_output("t1.load", 32'(q), 32'h0000000b);
        apply_stimulus(1'b1, 2'b00, 1'b0, 1'b0, 4'b0000);
        tick();
        check_state("t1.rst", 4'b0000, 2'd0, 1'b0);
        check_output("t1.sout_r", 32'(sout_r), 32'h0);
        check_output("t1.sout_l", 32'(sout_l), 32'h0);

        // 2: load 1010, then hold three edges
        apply_stimulus(1'b0, 2'b11, 1'b0, 1'b0, 4'b1010);
        tick();
        check_state("t2.load", 4'b1010, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 2'b00, 1'b1, 1'b1, 4'b1111);
            tick();
            check_state($sformatf("t2.hold%0d", i), 4'b1010, 2'd0, 1'b0);
        end

        // 3: SIPO right shifts of 1,1,0,1 from q=1010
        apply_stimulus(1'b0, 2'b01, 1'b1, 1'b0, 4'b0000); tick();
        check_state("t3.s1", 4'b1101, 2'd1, 1'b0);
        apply_stimulus(1'b0, 2'b01, 1'b1, 1'b0, 4'b0000); tick();
        check_state("t3.s2", 4'b1110, 2'd2, 1'b0);
        apply_stimulus(1'b0, 2'b01, 1'b0, 1'b0, 4'b0000); tick();
        check_state("t3.s3", 4'b0111, 2'd3, 1'b0);
        apply_stimulus(1'b0, 2'b01, 1'b1, 1'b0, 4'b0000); tick();
        check_state("t3.s4", 4'b1011, 2'd0, 1'b1);

        // 4: PISO, load 1001 then four left shifts; sout_l checked before each edge
        apply_stimulus(1'b0, 2'b11, 1'b0, 1'b0, 4'b1001); tick();
        check_state("t4.load", 4'b1001, 2'd0, 1'b0);
        apply_stimulus(1'b0, 2'b10, 1'b0, 1'b0, 4'b0000);
        check_output("t4.sout_l0", 32'(sout_l), 32'h1); tick();
        check_state("t4.s1", 4'b0010, 2'd1, 1'b0);
        check_output("t4.sout_l1", 32'(sout_l), 32'h0); tick();
        check_state("t4.s2", 4'b0100, 2'd2, 1'b0);
        check_output("t4.sout_l2", 32'(sout_l), 32'h0); tick();
        check_state("t4.s3", 4'b1000, 2'd3, 1'b0);
        check_output("t4.sout_l3", 32'(sout_l), 32'h1); tick();
        check_state("t4.s4", 4'b0000, 2'd0, 1'b1);

        // 5: two right shifts, then reset together with a load, then a full word
        apply_stimulus(1'b0, 2'b01, 1'b0, 1'b0, 4'b0000); tick();
        check_state("t5.s1", 4'b0000, 2'd1, 1'b0);
        apply_stimulus(1'b0, 2'b01, 1'b0, 1'b0, 4'b0000); tick();
        check_state("t5.s2", 4'b0000, 2'd2, 1'b0);
        apply_stimulus(1'b1, 2'b11, 1'b0, 1'b0, 4'b1111); tick();
        check_state("t5.rst_load", 4'b0000, 2'd0, 1'b0);
        apply_stimulus(1'b0, 2'b01, 1'b1, 1'b0, 4'b0000); tick();
        check_state("t5.r1", 4'b1000, 2'd1, 1'b0);
        tick();
        check_state("t5.r2", 4'b1100, 2'd2, 1'b0);
        tick();
        check_state("t5.r3", 4'b1110, 2'd3, 1'b0);
        tick();
        check_state("t5.r4", 4'b1111, 2'd0, 1'b1);

        // 6: load 1000 then four right shifts with sin_r=0
`ifdef UNIV_SHIFT_ROTATE_EN
        rot_last  = 4'b1000;
        wide_last = 8'hA5;
`else
        rot_last  = 4'b0000;
        wide_last = 8'h00;
`endif
        apply_stimulus(1'b0, 2'b11, 1'b0, 1'b0, 4'b1000); tick();
        check_state("t6.load", 4'b1000, 2'd0, 1'b0);
        apply_stimulus(1'b0, 2'b01, 1'b0, 1'b0, 4'b0000); tick();
        check_state("t6.s1", 4'b0100, 2'd1, 1'b0);
        tick();
        check_state("t6.s2", 4'b0010, 2'd2, 1'b0);
        tick();
        check_state("t6.s3", 4'b0001, 2'd3, 1'b0);
        tick();
        check_state("t6.s4", rot_last, 2'd0, 1'b1);
        apply_stimulus(1'b0, 2'b00, 1'b0, 1'b0, 4'b0000); tick();
        check_output("t6.hold_wd", 32'(word_done), 32'h0);

        // WIDTH=8: load A5, eight left shifts, word_done only on the eighth
        rst8 = 1'b0; mode8 = 2'b11; pin8 = 8'hA5; tick();
        check_output("w8.load", 32'(q8), 32'h000000a5);
        check_output("w8.load_cnt", 32'(cnt8), 32'h0);
        mode8 = 2'b10; sin_l8 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_output($sformatf("w8.cnt%0d", i), 32'(cnt8), 32'(i % 8));
            check_output($sformatf("w8.wd%0d", i), 32'(word_done8), 32'(i == 8));
        end
        check_output("w8.final_q", 32'(q8), 32'(wide_last));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
